// File: rtl/gf180mcu_fd_sc_mcu9t5v0__and3_bist.sv
// Self-test driver/monitor for a 3-input AND cell: sweeps all A1/A2/A3 combinations,
// samples Z after a settle window, and records error count and first failing vector.
module gf180mcu_fd_sc_mcu9t5v0__and3_bist #(
  parameter int N_PASSES = 1,
  parameter int SETTLE   = 2
) (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       Z_IN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] ERR_CNT,
  output logic       FAIL_VLD,
  output logic [2:0] FAIL_VEC
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [7:0] LAST_P   = 8'(N_PASSES - 1);

  state_e      state_q, state_d;
  logic [2:0]  v_q, v_d;
  logic [3:0]  s_q, s_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  err_q, err_d;
  logic        fvld_q, fvld_d;
  logic [2:0]  fvec_q, fvec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        mismatch;

  // Case inequality so an undriven or X output from the cell counts as a failure in simulation.
  assign mismatch = (Z_IN !== (&v_q));

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    s_d     = s_q;
    p_d     = p_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    case (state_q)
      IDLE, FINISH: begin
        if (START) begin
          state_d = RUN;
          v_d     = 3'd0;
          s_d     = 4'd0;
          p_d     = 8'd0;
          err_d   = 8'd0;
          fvld_d  = 1'b0;
          fvec_d  = 3'd0;
        end
      end
      RUN: begin
        if (s_q == SETTLE_C) begin
          if (mismatch) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fvec_d = v_q;
            end
          end
          s_d = 4'd0;
          // v wraps to 0 on the last vector, so A is already back at 000 in FINISH.
          v_d = v_q + 3'd1;
          if (v_q == 3'd7) begin
            p_d = p_q + 8'd1;
            if (p_q == LAST_P) state_d = FINISH;
          end
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FINISH);
    pass_d = (state_d == FINISH) && (err_d == 8'd0);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      v_q     <= 3'd0;
      s_q     <= 4'd0;
      p_q     <= 8'd0;
      err_q   <= 8'd0;
      fvld_q  <= 1'b0;
      fvec_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      s_q     <= s_d;
      p_q     <= p_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A1       = v_q[0];
  assign A2       = v_q[1];
  assign A3       = v_q[2];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VLD = fvld_q;
  assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__and3_bist.sv
// Directed bench: three BIST instances with different sweep parameters driving modelled AND cells.
module tb_gf180mcu_fd_sc_mcu9t5v0__and3_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Instance A: N_PASSES=1, SETTLE=2, configurable cell model
  logic rn_a = 1'b0, st_a = 1'b0, za;
  int   mode_a = 0;
  logic a1_a, a2_a, a3_a, busy_a, done_a, pass_a, fvld_a;
  logic [7:0] err_a;
  logic [2:0] fvec_a, a_a;
  assign a_a = {a3_a, a2_a, a1_a};

  always_comb begin
    za = 1'b0;
    case (mode_a)
      0: za = &a_a;
      1: za = a_a[0] & a_a[1];
      2: za = 1'b1;
      3: za = 1'b0;
      4: za = a_a[0];
      5: za = ~&a_a;
      6: za = a_a[2];
      default: za = 1'b0;
    endcase
  end

  gf180mcu_fd_sc_mcu9t5v0__and3_bist #(.N_PASSES(1), .SETTLE(2)) u_a (
    .CLK(clk), .RN(rn_a), .START(st_a), .Z_IN(za),
    .A1(a1_a), .A2(a2_a), .A3(a3_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
    .ERR_CNT(err_a), .FAIL_VLD(fvld_a), .FAIL_VEC(fvec_a));

  // Instance B: N_PASSES=2, SETTLE=0, stuck-at-1 cell
  logic rn_bc = 1'b0, st_b = 1'b0, st_c = 1'b0;
  logic a1_b, a2_b, a3_b, busy_b, done_b, pass_b, fvld_b;
  logic [7:0] err_b;
  logic [2:0] fvec_b, a_b;
  assign a_b = {a3_b, a2_b, a1_b};

  gf180mcu_fd_sc_mcu9t5v0__and3_bist #(.N_PASSES(2), .SETTLE(0)) u_b (
    .CLK(clk), .RN(rn_bc), .START(st_b), .Z_IN(1'b1),
    .A1(a1_b), .A2(a2_b), .A3(a3_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
    .ERR_CNT(err_b), .FAIL_VLD(fvld_b), .FAIL_VEC(fvec_b));

  // Instance C: N_PASSES=255, SETTLE=0, stuck-at-0 cell
  logic a1_c, a2_c, a3_c, busy_c, done_c, pass_c, fvld_c;
  logic [7:0] err_c;
  logic [2:0] fvec_c;

  gf180mcu_fd_sc_mcu9t5v0__and3_bist #(.N_PASSES(255), .SETTLE(0)) u_c (
    .CLK(clk), .RN(rn_bc), .START(st_c), .Z_IN(1'b0),
    .A1(a1_c), .A2(a2_c), .A3(a3_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c),
    .ERR_CNT(err_c), .FAIL_VLD(fvld_c), .FAIL_VEC(fvec_c));

  // Pulse START on instance A and count edges until DONE; checks A = len/3 along the way.
  task automatic run_a(output int len, output bit seq_ok);
    @(negedge clk) st_a = 1'b1;
    @(negedge clk) st_a = 1'b0;
    len = 0;
    seq_ok = busy_a && !done_a && (a_a == 3'd0);
    while (!done_a && len < 5000) begin
      @(negedge clk);
      len++;
      if (!done_a && a_a != 3'(len / 3)) seq_ok = 1'b0;
    end
  endtask

  typedef struct {
    int mode;
    int err;
    int fvld;
    int fvec;
    int pass;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int len;
    bit seq_ok;
    int k;

    tbl[0] = '{0, 0, 0, 0, 1};   // ideal cell
    tbl[1] = '{1, 1, 1, 3, 0};   // A3 ignored: only 011 fails
    tbl[2] = '{2, 7, 1, 0, 0};   // stuck-at-1
    tbl[3] = '{3, 1, 1, 7, 0};   // stuck-at-0
    tbl[4] = '{4, 3, 1, 1, 0};   // Z=A1: 001,011,101 fail
    tbl[5] = '{5, 8, 1, 0, 0};   // inverted output
    tbl[6] = '{6, 3, 1, 4, 0};   // Z=A3: 100,101,110 fail

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_a", int'({a_a, busy_a, done_a, pass_a, err_a, fvld_a, fvec_a}), 0);
    chk("reset_b", int'({a_b, busy_b, done_b, pass_b, err_b, fvld_b, fvec_b}), 0);
    chk("reset_c", int'({a1_c, a2_c, a3_c, busy_c, done_c, pass_c, err_c, fvld_c, fvec_c}), 0);
    rn_a = 1'b1;
    rn_bc = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      mode_a = tbl[i].mode;
      run_a(len, seq_ok);
      chk($sformatf("v%0d_len", i), len, 24);
      chk($sformatf("v%0d_seq", i), int'(seq_ok), 1);
      chk($sformatf("v%0d_done", i), int'(done_a), 1);
      chk($sformatf("v%0d_busy", i), int'(busy_a), 0);
      chk($sformatf("v%0d_pass", i), int'(pass_a), tbl[i].pass);
      chk($sformatf("v%0d_err", i), int'(err_a), tbl[i].err);
      chk($sformatf("v%0d_fvld", i), int'(fvld_a), tbl[i].fvld);
      chk($sformatf("v%0d_fvec", i), int'(fvec_a), tbl[i].fvec);
      chk($sformatf("v%0d_a_idle", i), int'(a_a), 0);
    end

    // Reset mid-run at vector 5 with a stuck-at-1 cell
    mode_a = 2;
    @(negedge clk) st_a = 1'b1;
    @(negedge clk) st_a = 1'b0;
    k = 0;
    while (a_a != 3'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_v5", int'(a_a), 5);
    chk("mid_err_before", int'(err_a), 5);
    #2 rn_a = 1'b0;
    #1 chk("mid_async_clear", int'({a_a, busy_a, done_a, pass_a, err_a, fvld_a, fvec_a}), 0);
    @(negedge clk) rn_a = 1'b1;
    mode_a = 0;
    run_a(len, seq_ok);
    chk("post_rst_len", len, 24);
    chk("post_rst_seq", int'(seq_ok), 1);
    chk("post_rst_err", int'(err_a), 0);
    chk("post_rst_pass", int'(pass_a), 1);

    // START held high: back-to-back runs with one visible DONE cycle
    @(negedge clk) st_a = 1'b1;
    k = 0;
    while (!done_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("held_done", int'({done_a, busy_a}), 2);
    @(negedge clk);
    chk("held_rearm", int'({done_a, busy_a, a_a}), 8);
    st_a = 1'b0;
    len = 0;
    while (!done_a && len < 100) begin
      @(negedge clk);
      len++;
    end
    chk("held_len2", len, 24);
    chk("held_pass2", int'(pass_a), 1);

    // Instance B: stuck-at-1, two passes, single-cycle vectors
    @(negedge clk) st_b = 1'b1;
    @(negedge clk) st_b = 1'b0;
    len = 0;
    seq_ok = busy_b && (a_b == 3'd0);
    while (!done_b && len < 200) begin
      @(negedge clk);
      len++;
      if (!done_b && a_b != 3'(len % 8)) seq_ok = 1'b0;
    end
    chk("b_len", len, 16);
    chk("b_seq", int'(seq_ok), 1);
    chk("b_err", int'(err_b), 14);
    chk("b_fvld", int'(fvld_b), 1);
    chk("b_fvec", int'(fvec_b), 0);
    chk("b_pass", int'(pass_b), 0);

    // Instance C: stuck-at-0, 255 passes, extra START while busy
    @(negedge clk) st_c = 1'b1;
    @(negedge clk) st_c = 1'b0;
    len = 0;
    while (!done_c && len < 5000) begin
      @(negedge clk);
      len++;
      st_c = (len == 100);
    end
    st_c = 1'b0;
    chk("c_len", len, 2040);
    chk("c_err_sat", int'(err_c), 255);
    chk("c_fvld", int'(fvld_c), 1);
    chk("c_fvec", int'(fvec_c), 7);
    chk("c_pass", int'(pass_c), 0);
    @(negedge clk);
    chk("c_err_stable", int'({done_c, err_c}), 256 + 255);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
